// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: widths, func encodings, reservation-station entry
// layout and the per-function execution latency lookup.
package tomasulo_pkg;
  localparam int DATA_W = 8;
  localparam int TAG_W  = 3;
  localparam int REG_W  = 4;
  localparam int FN_W   = 4;

  localparam logic [FN_W-1:0] FN_ADD = 4'b0000;
  localparam logic [FN_W-1:0] FN_SUB = 4'b0001;
  localparam logic [FN_W-1:0] FN_MUL = 4'b0010;
  localparam logic [FN_W-1:0] FN_DIV = 4'b0011;
  localparam logic [FN_W-1:0] FN_LD  = 4'b0100;
  localparam logic [FN_W-1:0] FN_ST  = 4'b0101;

  typedef struct packed {
    logic              valid;
    logic [FN_W-1:0]   func;
    logic [REG_W-1:0]  rd;
    logic [TAG_W-1:0]  rob;
    logic              rdy1;
    logic [DATA_W-1:0] v1;
    logic [TAG_W-1:0]  q1;
    logic              rdy2;
    logic [DATA_W-1:0] v2;
    logic [TAG_W-1:0]  q2;
  } rs_entry_t;

  typedef struct packed {
    logic [FN_W-1:0]   func;
    logic [REG_W-1:0]  rd;
    logic [TAG_W-1:0]  rob;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
  } exec_out_t;

  // Latencies come from the instantiating module's parameters.
  function automatic int fn_latency(input logic [FN_W-1:0] f, input int l_as,
                                    input int l_mul, input int l_div, input int l_mem);
    case (f)
      FN_ADD, FN_SUB: return l_as;
      FN_MUL:         return l_mul;
      FN_DIV:         return l_div;
      FN_LD, FN_ST:   return l_mem;
      default:        return 1;
    endcase
  endfunction
endpackage

// File: rtl/rs_dispatch_if.sv
// Issue, CDB and execute-stage bundle for the reservation station.
interface rs_dispatch_if;
  import tomasulo_pkg::*;

  logic              iss_valid, iss_ready;
  logic [FN_W-1:0]   iss_func;
  logic [REG_W-1:0]  iss_rd;
  logic [TAG_W-1:0]  iss_rob;
  logic              iss_rdy1, iss_rdy2;
  logic [DATA_W-1:0] iss_v1, iss_v2;
  logic [TAG_W-1:0]  iss_q1, iss_q2;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  logic [DATA_W-1:0] rs1_data, rs2_data;
  logic [FN_W-1:0]   func;
  logic [TAG_W-1:0]  rob_ind;
  logic [REG_W-1:0]  rd;
  logic              exec_b;

  modport master (
    output iss_valid, iss_func, iss_rd, iss_rob, iss_rdy1, iss_v1, iss_q1,
           iss_rdy2, iss_v2, iss_q2, cdb_valid, cdb_tag, cdb_data,
    input  iss_ready, rs1_data, rs2_data, func, rob_ind, rd, exec_b
  );
  modport slave (
    input  iss_valid, iss_func, iss_rd, iss_rob, iss_rdy1, iss_v1, iss_q1,
           iss_rdy2, iss_v2, iss_q2, cdb_valid, cdb_tag, cdb_data,
    output iss_ready, rs1_data, rs2_data, func, rob_ind, rd, exec_b
  );
endinterface

// File: rtl/rs_entry_wakeup.sv
// One operand slot's CDB snoop: captures the broadcast when it carries the awaited tag.
module rs_entry_wakeup
  import tomasulo_pkg::*;
(
  input  logic              valid_i,
  input  logic              rdy_i,
  input  logic [DATA_W-1:0] val_i,
  input  logic [TAG_W-1:0]  q_i,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              rdy_o,
  output logic [DATA_W-1:0] val_o
);
  logic hit;

  assign hit   = valid_i && !rdy_i && cdb_valid && (q_i == cdb_tag);
  assign rdy_o = rdy_i || hit;
  assign val_o = hit ? cdb_data : val_i;
endmodule

// File: rtl/rs_dispatch.sv
// Collapsing reservation station: oldest-ready select, latency-gated dispatch
// and CDB wakeup, driving the execute stage with a one-cycle strobe.
module rs_dispatch
  import tomasulo_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LAT_AS  = 2,
  parameter int LAT_MUL = 4,
  parameter int LAT_DIV = 6,
  parameter int LAT_MEM = 2
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          flush,
  rs_dispatch_if.slave  io,
  output logic [3:0]    count
);
  localparam int CNT_W  = 4;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int BUSY_W = 8;

  rs_entry_t ent_q [DEPTH];
  rs_entry_t ent_d [DEPTH];
  rs_entry_t nxt   [DEPTH];
  rs_entry_t new_e;

  logic [DEPTH-1:0]             wk_rdy1, wk_rdy2;
  logic [DEPTH-1:0][DATA_W-1:0] wk_v1, wk_v2;

  logic [CNT_W-1:0]  count_q, count_d, base;
  logic [BUSY_W-1:0] busy_q, busy_d;
  logic              exec_q, exec_d;
  exec_out_t         out_q, out_d;
  logic              found, disp, accept, hit1, hit2;
  logic [IDX_W-1:0]  sel;

  for (genvar g = 0; g < DEPTH; g++) begin : g_wk
    rs_entry_wakeup u_wk1 (
      .valid_i(ent_q[g].valid), .rdy_i(ent_q[g].rdy1), .val_i(ent_q[g].v1), .q_i(ent_q[g].q1),
      .cdb_valid(io.cdb_valid), .cdb_tag(io.cdb_tag), .cdb_data(io.cdb_data),
      .rdy_o(wk_rdy1[g]), .val_o(wk_v1[g])
    );
    rs_entry_wakeup u_wk2 (
      .valid_i(ent_q[g].valid), .rdy_i(ent_q[g].rdy2), .val_i(ent_q[g].v2), .q_i(ent_q[g].q2),
      .cdb_valid(io.cdb_valid), .cdb_tag(io.cdb_tag), .cdb_data(io.cdb_data),
      .rdy_o(wk_rdy2[g]), .val_o(wk_v2[g])
    );
  end

  assign io.iss_ready = (count_q < CNT_W'(DEPTH));
  assign count        = count_q;
  assign io.exec_b    = exec_q;
  assign io.rs1_data  = out_q.v1;
  assign io.rs2_data  = out_q.v2;
  assign io.func      = out_q.func;
  assign io.rob_ind   = out_q.rob;
  assign io.rd        = out_q.rd;

  always_comb begin
    // Select looks only at registered readiness, so a wakeup costs one cycle.
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2) begin
        found = 1'b1;
        sel   = IDX_W'(i);
      end
    end
    disp   = found && (busy_q == '0) && !flush;
    accept = io.iss_valid && io.iss_ready && !flush;

    hit1        = !io.iss_rdy1 && io.cdb_valid && (io.iss_q1 == io.cdb_tag);
    hit2        = !io.iss_rdy2 && io.cdb_valid && (io.iss_q2 == io.cdb_tag);
    new_e.valid = 1'b1;
    new_e.func  = io.iss_func;
    new_e.rd    = io.iss_rd;
    new_e.rob   = io.iss_rob;
    new_e.rdy1  = io.iss_rdy1 || hit1;
    new_e.v1    = hit1 ? io.cdb_data : io.iss_v1;
    new_e.q1    = io.iss_q1;
    new_e.rdy2  = io.iss_rdy2 || hit2;
    new_e.v2    = hit2 ? io.cdb_data : io.iss_v2;
    new_e.q2    = io.iss_q2;

    for (int i = 0; i < DEPTH; i++) begin
      nxt[i]      = ent_q[i];
      nxt[i].rdy1 = wk_rdy1[i];
      nxt[i].v1   = wk_v1[i];
      nxt[i].rdy2 = wk_rdy2[i];
      nxt[i].v2   = wk_v2[i];
      ent_d[i]    = nxt[i];
    end
    if (disp) begin
      for (int i = 0; i < DEPTH - 1; i++)
        if (i >= int'(sel)) ent_d[i] = nxt[i+1];
      ent_d[DEPTH-1] = '0;
    end

    // New entry lands just behind the survivors of this cycle's compaction.
    base = count_q - CNT_W'(disp);
    if (accept)
      for (int i = 0; i < DEPTH; i++)
        if (base == CNT_W'(i)) ent_d[i] = new_e;
    count_d = base + CNT_W'(accept);

    if (disp)                busy_d = BUSY_W'(fn_latency(ent_q[sel].func, LAT_AS, LAT_MUL, LAT_DIV, LAT_MEM) - 1);
    else if (busy_q != '0)   busy_d = busy_q - BUSY_W'(1);
    else                     busy_d = busy_q;

    exec_d = disp;
    out_d  = out_q;
    if (disp) begin
      out_d.func = ent_q[sel].func;
      out_d.rd   = ent_q[sel].rd;
      out_d.rob  = ent_q[sel].rob;
      out_d.v1   = ent_q[sel].v1;
      out_d.v2   = ent_q[sel].v2;
    end

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      count_d = '0;
      busy_d  = '0;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
      busy_q  <= '0;
      exec_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      count_q <= count_d;
      busy_q  <= busy_d;
      exec_q  <= exec_d;
      out_q   <= out_d;
    end
  end
endmodule

// File: tb/tb_rs_dispatch.sv
// Directed bench for rs_dispatch: issue, wakeup, latency spacing, full, flush, reset.
module tb_rs_dispatch;
  import tomasulo_pkg::*;

  logic       clk1;
  logic       rst_n;
  logic       flush;
  logic [3:0] count;
  int         checks = 0;
  int         errors = 0;
  int         n;
  int         seen;

  rs_dispatch_if bus();

  rs_dispatch #(.DEPTH(4), .LAT_AS(2), .LAT_MUL(4), .LAT_DIV(6), .LAT_MEM(2)) dut (
    .clk1(clk1), .rst_n(rst_n), .flush(flush), .io(bus), .count(count)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue_tick(input logic [3:0] f, input logic [2:0] rob, input logic [3:0] rdv,
                            input logic r1, input logic [7:0] v1, input logic [2:0] q1,
                            input logic r2, input logic [7:0] v2, input logic [2:0] q2);
    bus.iss_valid = 1'b1;
    bus.iss_func  = f;
    bus.iss_rob   = rob;
    bus.iss_rd    = rdv;
    bus.iss_rdy1  = r1;
    bus.iss_v1    = v1;
    bus.iss_q1    = q1;
    bus.iss_rdy2  = r2;
    bus.iss_v2    = v2;
    bus.iss_q2    = q2;
    tick();
    bus.iss_valid = 1'b0;
  endtask

  task automatic cdb_tick(input logic [2:0] tag, input logic [7:0] data);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_data  = data;
    tick();
    bus.cdb_valid = 1'b0;
  endtask

  task automatic wait_exec(input int max, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (bus.exec_b !== 1'b1 && cyc < max);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.iss_valid = 1'b0; bus.iss_func = '0; bus.iss_rd = '0; bus.iss_rob = '0;
    bus.iss_rdy1 = 1'b0; bus.iss_v1 = '0; bus.iss_q1 = '0;
    bus.iss_rdy2 = 1'b0; bus.iss_v2 = '0; bus.iss_q2 = '0;
    bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_data = '0;
    repeat (2) tick();
    chk("rst_exec_b", bus.exec_b, 0);
    chk("rst_count", count, 0);
    chk("rst_rs1", bus.rs1_data, 0);
    chk("rst_rob", bus.rob_ind, 0);
    chk("rst_ready", bus.iss_ready, 1);
    rst_n = 1'b1;
    tick();

    // Ready issue: dispatch one cycle after accept.
    issue_tick(FN_ADD, 3'd1, 4'd3, 1'b1, 8'd5, 3'd0, 1'b1, 8'd7, 3'd0);
    chk("t1_count_after_issue", count, 1);
    chk("t1_no_exec_yet", bus.exec_b, 0);
    tick();
    chk("t1_exec", bus.exec_b, 1);
    chk("t1_rs1", bus.rs1_data, 8'd5);
    chk("t1_rs2", bus.rs2_data, 8'd7);
    chk("t1_func", bus.func, FN_ADD);
    chk("t1_rob", bus.rob_ind, 1);
    chk("t1_rd", bus.rd, 3);
    chk("t1_count_zero", count, 0);
    tick();
    chk("t1_pulse_one_cycle", bus.exec_b, 0);
    chk("t1_rs1_hold", bus.rs1_data, 8'd5);
    repeat (3) tick();

    // Operand wait and CDB wakeup.
    issue_tick(FN_MUL, 3'd2, 4'd5, 1'b0, 8'd0, 3'd4, 1'b1, 8'd2, 3'd0);
    tick();
    chk("t2_waiting", bus.exec_b, 0);
    cdb_tick(3'd4, 8'd9);
    chk("t2_not_same_cycle", bus.exec_b, 0);
    tick();
    chk("t2_exec", bus.exec_b, 1);
    chk("t2_rs1_woken", bus.rs1_data, 8'd9);
    chk("t2_rs2", bus.rs2_data, 8'd2);
    chk("t2_func", bus.func, FN_MUL);
    repeat (6) tick();

    // DIV then ADD back to back: 6-cycle spacing; simultaneous issue+dispatch keeps count.
    issue_tick(FN_DIV, 3'd3, 4'd1, 1'b1, 8'd20, 3'd0, 1'b1, 8'd4, 3'd0);
    issue_tick(FN_ADD, 3'd4, 4'd2, 1'b1, 8'd1, 3'd0, 1'b1, 8'd1, 3'd0);
    chk("t3_div_exec", bus.exec_b, 1);
    chk("t3_div_func", bus.func, FN_DIV);
    chk("t3_count_issue_disp", count, 1);
    wait_exec(20, n);
    chk("t3_div_spacing", n, 6);
    chk("t3_add_rob", bus.rob_ind, 4);
    repeat (3) tick();
    issue_tick(FN_MUL, 3'd5, 4'd1, 1'b1, 8'd3, 3'd0, 1'b1, 8'd3, 3'd0);
    issue_tick(FN_ADD, 3'd6, 4'd2, 1'b1, 8'd1, 3'd0, 1'b1, 8'd1, 3'd0);
    chk("t3_mul_exec", bus.exec_b, 1);
    chk("t3_mul_func", bus.func, FN_MUL);
    wait_exec(20, n);
    chk("t3_mul_spacing", n, 4);
    chk("t3_add2_rob", bus.rob_ind, 6);
    repeat (3) tick();

    // Full station: four waiters on tag 7, fifth issue refused.
    for (int i = 0; i < 4; i++)
      issue_tick(FN_ADD, 3'(i), 4'(i + 8), 1'b0, 8'd0, 3'd7, 1'b1, 8'(i), 3'd0);
    chk("t4_count_full", count, 4);
    chk("t4_not_ready", bus.iss_ready, 0);
    issue_tick(FN_ADD, 3'd5, 4'd0, 1'b1, 8'd0, 3'd0, 1'b1, 8'd0, 3'd0);
    chk("t4_count_still_full", count, 4);
    chk("t4_no_exec_full", bus.exec_b, 0);
    cdb_tick(3'd7, 8'h11);
    wait_exec(5, n);
    chk("t4_first_latency", n, 1);
    chk("t4_first_rob", bus.rob_ind, 0);
    chk("t4_first_rs1", bus.rs1_data, 8'h11);
    chk("t4_count_after_first", count, 3);
    chk("t4_ready_after_first", bus.iss_ready, 1);
    for (int k = 1; k < 4; k++) begin
      wait_exec(10, n);
      chk("t4_spacing", n, 2);
      chk("t4_order_rob", bus.rob_ind, 32'(k));
      chk("t4_order_rs2", bus.rs2_data, 32'(k));
    end
    chk("t4_drained", count, 0);
    repeat (3) tick();

    // Same-cycle CDB at issue.
    bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd5; bus.cdb_data = 8'hAA;
    issue_tick(FN_SUB, 3'd6, 4'd1, 1'b1, 8'h10, 3'd0, 1'b0, 8'h00, 3'd5);
    bus.cdb_valid = 1'b0;
    tick();
    chk("t5_exec", bus.exec_b, 1);
    chk("t5_rs2_captured", bus.rs2_data, 8'hAA);
    chk("t5_rs1", bus.rs1_data, 8'h10);
    chk("t5_func", bus.func, FN_SUB);
    repeat (3) tick();

    // Flush with three waiters while DIV keeps the unit busy.
    issue_tick(FN_DIV, 3'd0, 4'd7, 1'b1, 8'd8, 3'd0, 1'b1, 8'd2, 3'd0);
    for (int i = 1; i < 4; i++)
      issue_tick(FN_ADD, 3'(i), 4'd1, 1'b0, 8'd0, 3'd7, 1'b1, 8'd0, 3'd0);
    chk("t6_count_before_flush", count, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_count_flushed", count, 0);
    chk("t6_exec_flushed", bus.exec_b, 0);
    chk("t6_func_held", bus.func, FN_DIV);
    chk("t6_ready", bus.iss_ready, 1);
    cdb_tick(3'd7, 8'h55);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.exec_b === 1'b1) seen++;
    end
    chk("t6_no_exec_after_flush", seen, 0);

    // Reset during an exec_b pulse.
    issue_tick(FN_ADD, 3'd5, 4'd2, 1'b1, 8'h33, 3'd0, 1'b1, 8'h44, 3'd0);
    tick();
    chk("t7_exec_before_reset", bus.exec_b, 1);
    chk("t7_rs1_before_reset", bus.rs1_data, 8'h33);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_exec_cut", bus.exec_b, 0);
    chk("t7_rs1_zero", bus.rs1_data, 0);
    chk("t7_rs2_zero", bus.rs2_data, 0);
    chk("t7_func_zero", bus.func, 0);
    chk("t7_rob_zero", bus.rob_ind, 0);
    chk("t7_rd_zero", bus.rd, 0);
    chk("t7_count_zero", count, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("t7_idle_after_reset", bus.exec_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
